mont_exp_ctrl: RTL and testbench
================================

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter N, default 1024: operand/modulus width in bits.
REQ-002 Parameter E, default 16: exponent width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new exponentiation; sampled only in IDLE.
REQ-006 in_x  input  N  base x, x < M.
REQ-007 in_e  input  E  exponent e.
REQ-008 in_m  input  N  odd modulus M.
REQ-009 in_r  input  N  R mod M, where R = 2^N.
REQ-010 in_r2  input  N  R^2 mod M.
REQ-011 mm_start  output  1  one-cycle start pulse to the Montgomery multiplier.
REQ-012 mm_a, mm_b, mm_m  output  N each  multiplier operands and modulus.
REQ-013 mm_result  input  N  multiplier result, a*b*R^-1 mod M, fully reduced.
REQ-014 mm_done  input  1  one-cycle result-valid pulse from the multiplier.
REQ-015 result  output  N  x^e mod M; valid while done=1, held until the next accepted start.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 busy  output  1  high from the cycle after start is accepted until the done cycle inclusive.
REQ-018 mm_count  output  8  number of mm_start pulses issued in the current job; cleared on start acceptance.

Function
REQ-019 At start acceptance in IDLE, the block SHALL capture in_x, in_e, in_m, in_r and in_r2; later input changes SHALL NOT affect the job.
REQ-020 States: IDLE, TOMONT, W_TOMONT, SQR, W_SQR, MUL, W_MUL, FROMMONT, W_FROM, DONE.
REQ-021 IDLE->TOMONT on start. TOMONT issues mm(x, R2) and goes to W_TOMONT. On mm_done: xm<=mm_result, acc<=R mod M, idx<=E-1, go to SQR.
REQ-022 SQR issues mm(acc, acc) and goes to W_SQR. On mm_done: acc<=mm_result; go to MUL if e[idx]=1, otherwise go to the bit-advance step.
REQ-023 MUL issues mm(acc, xm) and goes to W_MUL. On mm_done: acc<=mm_result, then perform the bit-advance step.
REQ-024 Bit-advance step: if idx=0, go to FROMMONT; otherwise idx<=idx-1 and go to SQR.
REQ-025 FROMMONT issues mm(acc, 1) and goes to W_FROM. On mm_done: result<=mm_result, go to DONE. DONE asserts done and goes to IDLE.
REQ-026 Every issue state SHALL assert mm_start for exactly one cycle and increment mm_count.
REQ-027 mm_a, mm_b and mm_m (mm_m = captured M) SHALL be registered and stable from the issue cycle through the mm_done cycle.
REQ-028 All E exponent bits SHALL be processed; no leading-zero skipping.
REQ-029 Total multiplications per job SHALL equal E + popcount(e) + 2.
REQ-030 mm_done SHALL be ignored outside W_* states. start SHALL be ignored outside IDLE.
REQ-031 e=0 SHALL yield result = 1, given M > 1.
REQ-032 Overhead: one cycle per issue state plus one DONE cycle; the multiplier latency is any value of 1 cycle or more.

Reset
REQ-033 On reset assertion, at any time including mid-job, the block SHALL enter IDLE immediately.
REQ-034 On reset, mm_start, done, busy, result, mm_count, mm_a, mm_b and mm_m SHALL be 0, and internal acc, xm and idx SHALL be cleared.
REQ-035 After reset deasserts, the first start in IDLE SHALL begin a clean job; any stale mm_done from an aborted job SHALL be ignored.

Verification
REQ-036 Bench SHALL use a behavioural Montgomery model with randomised latency from 1 to 20 cycles; all scenarios use N=8, E=4, M=13, in_r=9, in_r2=3.
REQ-037 Scenario: x=2, e=5 -> result=6, done one cycle, mm_count=8.
REQ-038 Scenario: x=2, e=0 -> result=1, mm_count=6.
REQ-039 Scenario: x=2, e=15 -> result=8, mm_count=10; mm_a and mm_b stable during every wait.
REQ-040 Scenario: start re-pulsed while busy and mm_done injected in SQR/MUL issue cycles -> no effect; result=6 for x=2, e=5.
REQ-041 Scenario: reset asserted in W_SQR, then released and a new job x=3, e=3 started -> all outputs 0 during reset; result=1 (27 mod 13), mm_count=8.

Source files
------------

// File: rtl/mont_exp_ctrl_if.sv
// ----------------------------------------------------------------------------
// Bundles for mont_exp_ctrl.
//
// mont_exp_host_if : job request/response between a host and the controller.
//   master = host, slave = controller.
//   start, in_x, in_e, in_m, in_r, in_r2   host -> controller
//   result, done, busy, mm_count           controller -> host
//
// mont_exp_mm_if : controller <-> Montgomery multiplier.
//   master = controller, slave = multiplier.
//   mm_start, mm_a, mm_b, mm_m             controller -> multiplier
//   mm_result, mm_done                     multiplier -> controller
// ----------------------------------------------------------------------------
interface mont_exp_host_if #(
    parameter int N = 1024,
    parameter int E = 16
);
    logic         start;
    logic [N-1:0] in_x;
    logic [E-1:0] in_e;
    logic [N-1:0] in_m;
    logic [N-1:0] in_r;
    logic [N-1:0] in_r2;
    logic [N-1:0] result;
    logic         done;
    logic         busy;
    logic [7:0]   mm_count;

    modport master (
        output start, in_x, in_e, in_m, in_r, in_r2,
        input  result, done, busy, mm_count
    );
    modport slave (
        input  start, in_x, in_e, in_m, in_r, in_r2,
        output result, done, busy, mm_count
    );
endinterface

interface mont_exp_mm_if #(
    parameter int N = 1024
);
    logic         mm_start;
    logic [N-1:0] mm_a;
    logic [N-1:0] mm_b;
    logic [N-1:0] mm_m;
    logic [N-1:0] mm_result;
    logic         mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );
    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

// File: rtl/mont_exp_ctrl.sv
// ----------------------------------------------------------------------------
// mont_exp_ctrl : sequencer for modular exponentiation x^e mod M using an
// external Montgomery multiplier (left-to-right square-and-multiply).
//
// Ports
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-high; returns to IDLE immediately
//   host   : job request (start + operands) and response (result, done,
//            busy, mm_count), slave side
//   mm     : multiplier operands/start pulse and result/done, master side
//
// Flow: convert x into the Montgomery domain (x*R2), seed acc with R mod M
// (Montgomery one), walk all E exponent bits MSB first squaring and
// conditionally multiplying, then leave the domain with acc*1.
// ----------------------------------------------------------------------------
module mont_exp_ctrl #(
    parameter int N = 1024,
    parameter int E = 16
) (
    input  logic           clk,
    input  logic           reset,
    mont_exp_host_if.slave host,
    mont_exp_mm_if.master  mm
);
    localparam int IW = (E > 1) ? $clog2(E) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_TOMONT, S_W_TOMONT, S_SQR, S_W_SQR,
        S_MUL, S_W_MUL, S_FROMMONT, S_W_FROM, S_DONE
    } state_t;

    state_t        r_state, w_next;

    logic [N-1:0]  r_x, r_r, r_r2;      // captured job operands
    logic [E-1:0]  r_e;
    logic [N-1:0]  r_xm;                // x in Montgomery domain
    logic [N-1:0]  r_acc;               // running accumulator (Montgomery domain)
    logic [IW-1:0] r_idx;               // current exponent bit
    logic          r_mm_start;
    logic [N-1:0]  r_mm_a, r_mm_b, r_mm_m;
    logic [N-1:0]  r_result;
    logic [7:0]    r_mm_count;

    logic          w_issue;
    logic [N-1:0]  w_op_a, w_op_b;
    logic          w_bit, w_last;
    logic          w_done, w_busy;

    assign w_bit  = r_e[r_idx];
    assign w_last = (r_idx == '0);

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------- next state / outputs
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_op_a  = '0;
        w_op_b  = '0;
        w_done  = 1'b0;
        w_busy  = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:     if (host.start) w_next = S_TOMONT;
            S_TOMONT: begin
                w_issue = 1'b1;
                w_op_a  = r_x;
                w_op_b  = r_r2;
                w_next  = S_W_TOMONT;
            end
            S_W_TOMONT: if (mm.mm_done) w_next = S_SQR;
            S_SQR: begin
                w_issue = 1'b1;
                w_op_a  = r_acc;
                w_op_b  = r_acc;
                w_next  = S_W_SQR;
            end
            S_W_SQR: begin
                if (mm.mm_done) begin
                    if (w_bit)       w_next = S_MUL;
                    else if (w_last) w_next = S_FROMMONT;
                    else             w_next = S_SQR;
                end
            end
            S_MUL: begin
                w_issue = 1'b1;
                w_op_a  = r_acc;
                w_op_b  = r_xm;
                w_next  = S_W_MUL;
            end
            S_W_MUL: begin
                if (mm.mm_done) w_next = w_last ? S_FROMMONT : S_SQR;
            end
            S_FROMMONT: begin
                // Multiplying by plain 1 strips the R factor.
                w_issue = 1'b1;
                w_op_a  = r_acc;
                w_op_b  = N'(1);
                w_next  = S_W_FROM;
            end
            S_W_FROM:   if (mm.mm_done) w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // Multiplier operands are loaded once in the issue cycle and then held,
    // so they stay stable for the whole multiplier latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x        <= '0;
            r_r        <= '0;
            r_r2       <= '0;
            r_e        <= '0;
            r_xm       <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
            r_result   <= '0;
            r_mm_count <= '0;
        end else begin
            r_mm_start <= w_issue;
            if (w_issue) begin
                r_mm_a     <= w_op_a;
                r_mm_b     <= w_op_b;
                r_mm_count <= r_mm_count + 8'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (host.start) begin
                        r_x        <= host.in_x;
                        r_e        <= host.in_e;
                        r_r        <= host.in_r;
                        r_r2       <= host.in_r2;
                        r_mm_m     <= host.in_m;
                        r_mm_count <= '0;
                    end
                end
                S_W_TOMONT: begin
                    if (mm.mm_done) begin
                        r_xm  <= mm.mm_result;
                        r_acc <= r_r;
                        r_idx <= IW'(E - 1);
                    end
                end
                S_W_SQR: begin
                    if (mm.mm_done) begin
                        r_acc <= mm.mm_result;
                        // A set bit defers the advance until after MUL.
                        if (!w_bit && !w_last) r_idx <= r_idx - IW'(1);
                    end
                end
                S_W_MUL: begin
                    if (mm.mm_done) begin
                        r_acc <= mm.mm_result;
                        if (!w_last) r_idx <= r_idx - IW'(1);
                    end
                end
                S_W_FROM: if (mm.mm_done) r_result <= mm.mm_result;
                default: ;
            endcase
        end
    end

    assign mm.mm_start   = r_mm_start;
    assign mm.mm_a       = r_mm_a;
    assign mm.mm_b       = r_mm_b;
    assign mm.mm_m       = r_mm_m;
    assign host.result   = r_result;
    assign host.done     = w_done;
    assign host.busy     = w_busy;
    assign host.mm_count = r_mm_count;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for mont_exp_ctrl with N=8, E=4, M=13, R mod M=9, R^2 mod M=3.
// A behavioural Montgomery multiplier answers each mm_start after 1..20
// cycles and watches operand stability; expected job results go through a
// scoreboard queue and are compared when done is seen.
// ----------------------------------------------------------------------------
module tb_mont_exp_ctrl;
    localparam int N = 8;
    localparam int E = 4;

    logic clk;
    logic reset;

    mont_exp_host_if #(.N(N), .E(E)) host ();
    mont_exp_mm_if   #(.N(N))        bus ();

    mont_exp_ctrl #(.N(N), .E(E)) dut (
        .clk   (clk),
        .reset (reset),
        .host  (host),
        .mm    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic [7:0]   cnt;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------ multiplier model
    function automatic logic [N-1:0] redc(input logic [N-1:0] a, b, m);
        logic [2*N+1:0] t;
        t = a * b;
        for (int i = 0; i < N; i++) begin
            if (t[0]) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t[N-1:0];
    endfunction

    logic         inj_en;      // spurious mm_done right after each real one
    logic         stale_done;  // manual stray mm_done pulse
    logic         m_busy, m_done, m_spur, m_prev;
    int           m_wait;
    int           lat;
    int           stab_err;
    logic [N-1:0] m_a, m_b, m_m, m_res, m_result;

    assign bus.mm_done   = m_done | m_spur | stale_done;
    assign bus.mm_result = (m_spur | stale_done) ? 8'hA5 : m_result;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_spur   <= 1'b0;
            m_prev   <= 1'b0;
            m_wait   <= 0;
            m_res    <= '0;
            m_result <= '0;
        end else begin
            m_done <= 1'b0;
            m_spur <= inj_en && m_done;
            m_prev <= bus.mm_start;
            if (bus.mm_start && (m_prev || m_busy)) stab_err <= stab_err + 1;
            if (!bus.mm_start && (m_busy || m_done) &&
                (bus.mm_a !== m_a || bus.mm_b !== m_b || bus.mm_m !== m_m))
                stab_err <= stab_err + 1;
            if (bus.mm_start) begin
                lat = $urandom_range(20, 1);
                m_a <= bus.mm_a;
                m_b <= bus.mm_b;
                m_m <= bus.mm_m;
                if (lat == 1) begin
                    m_done   <= 1'b1;
                    m_result <= redc(bus.mm_a, bus.mm_b, bus.mm_m);
                end else begin
                    m_busy <= 1'b1;
                    m_wait <= lat - 1;
                    m_res  <= redc(bus.mm_a, bus.mm_b, bus.mm_m);
                end
            end else if (m_busy) begin
                if (m_wait == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_res;
                    m_busy   <= 1'b0;
                end else begin
                    m_wait <= m_wait - 1;
                end
            end
        end
    end

    // ------------------------------------------------------- job driver
    task automatic run_job(input logic [N-1:0] x, input logic [E-1:0] e,
                           input logic [N-1:0] res, input logic [7:0] cnt,
                           input bit noisy);
        exp_t ex;
        bit   got;
        int   err0;
        sb.push_back('{res: res, cnt: cnt});
        @(negedge clk);
        err0       = stab_err;
        host.in_x  = x;
        host.in_e  = e;
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        check("busy_after_start", {31'd0, host.busy}, 32'd1);
        check("cnt_cleared", {24'd0, host.mm_count}, 32'd0);
        if (noisy) begin
            host.in_x = 8'd7;
            host.in_e = 4'd9;
            inj_en    = 1'b1;
        end
        got = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
            if (host.done) begin
                got        = 1'b1;
                host.start = 1'b0;
            end else begin
                host.start = noisy && (cyc % 5 == 3);
                @(negedge clk);
            end
        end
        host.start = 1'b0;
        inj_en     = 1'b0;
        ex = sb.pop_front();
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        check("result", {24'd0, host.result}, {24'd0, ex.res});
        check("mm_count", {24'd0, host.mm_count}, {24'd0, ex.cnt});
        check("busy_in_done", {31'd0, host.busy}, 32'd1);
        check("operand_stability", stab_err - err0, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, host.done}, 32'd0);
        check("busy_after_done", {31'd0, host.busy}, 32'd0);
        check("result_held", {24'd0, host.result}, {24'd0, ex.res});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mm_start"}, {31'd0, bus.mm_start}, 32'd0);
        check({tag, "_done"},     {31'd0, host.done},    32'd0);
        check({tag, "_busy"},     {31'd0, host.busy},    32'd0);
        check({tag, "_result"},   {24'd0, host.result},  32'd0);
        check({tag, "_mm_count"}, {24'd0, host.mm_count}, 32'd0);
        check({tag, "_mm_a"},     {24'd0, bus.mm_a},     32'd0);
        check({tag, "_mm_b"},     {24'd0, bus.mm_b},     32'd0);
        check({tag, "_mm_m"},     {24'd0, bus.mm_m},     32'd0);
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        stab_err   = 0;
        inj_en     = 1'b0;
        stale_done = 1'b0;
        reset      = 1'b1;
        host.start = 1'b0;
        host.in_x  = '0;
        host.in_e  = '0;
        host.in_m  = 8'd13;
        host.in_r  = 8'd9;
        host.in_r2 = 8'd3;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_job(8'd2, 4'd5,  8'd6, 8'd8,  1'b0);
        run_job(8'd2, 4'd0,  8'd1, 8'd6,  1'b0);
        run_job(8'd2, 4'd15, 8'd8, 8'd10, 1'b0);
        run_job(8'd2, 4'd5,  8'd6, 8'd8,  1'b1);

        // Abort a job while waiting on the first square.
        @(negedge clk);
        host.in_x  = 8'd2;
        host.in_e  = 4'd5;
        host.start = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        for (int cyc = 0; cyc < 200 && host.mm_count != 8'd2; cyc++) @(negedge clk);
        check("abort_in_w_sqr", {24'd0, host.mm_count}, 32'd2);
        reset = 1'b1;
        #1;
        check_all_zero("abort_reset");
        repeat (2) @(negedge clk);
        check_all_zero("abort_hold");
        reset = 1'b0;
        @(negedge clk);
        stale_done = 1'b1;
        @(negedge clk);
        stale_done = 1'b0;
        @(negedge clk);
        check("stale_done_busy", {31'd0, host.busy}, 32'd0);
        check("stale_done_result", {24'd0, host.result}, 32'd0);

        run_job(8'd3, 4'd3, 8'd1, 8'd8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
